dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side (A pipeline, B debug/preload) and dmem-side signals.
// Latency: none, wiring only.
// Backpressure: carried by a_gnt/b_gnt/a_stall; requesters hold req until granted.
interface dmem_arbiter_if #(
    parameter int N = 64
);
    // Port A: pipeline MEM stage
    logic         a_req;
    logic         a_we;
    logic [N-1:0] a_addr;
    logic [N-1:0] a_wdata;
    logic         a_gnt;
    logic         a_stall;
    logic [N-1:0] a_rdata;
    logic         a_rvalid;

    // Port B: debug/preload engine with burst ownership
    logic         b_req;
    logic         b_we;
    logic [N-1:0] b_addr;
    logic [N-1:0] b_wdata;
    logic         b_burst;
    logic         b_last;
    logic         b_gnt;
    logic [N-1:0] b_rdata;
    logic         b_rvalid;
    logic [7:0]   b_wait_cnt;

    // dmem side
    logic         mem_we;
    logic         mem_re;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    // Requesters plus the memory itself
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_stall, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata, b_burst, b_last,
        input  b_gnt, b_rdata, b_rvalid, b_wait_cnt,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );

    // The arbiter
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_stall, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata, b_burst, b_last,
        output b_gnt, b_rdata, b_rvalid, b_wait_cnt,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for single-port dmem: pipeline (A) vs debug/preload bursts (B).
// Latency: grant/mem drive combinational; load data + rvalid one cycle after grant.
// Backpressure: A stalls when denied; B holds req; DMEM_ARB_FAIRNESS_EN bounds B starvation.
module dmem_arbiter #(
    parameter int N        = 64,
    parameter int MAX_WAIT = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        B_BURST = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_a_gnt;
    logic       w_b_gnt;
    logic       w_force_b;
    logic [7:0] w_wait_cnt;

    logic [N-1:0] r_a_rdata;
    logic [N-1:0] r_b_rdata;
    logic         r_a_rvalid;
    logic         r_b_rvalid;

`ifdef DMEM_ARB_FAIRNESS_EN
    logic [7:0] r_wait_cnt;

    // Starvation counter: counts refused B cycles, saturates, clears on any B grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 8'd0;
        end else if (w_b_gnt) begin
            r_wait_cnt <= 8'd0;
        end else if (bus.b_req && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_wait_cnt = r_wait_cnt;
    assign w_force_b  = bus.b_req && (r_wait_cnt >= 8'(MAX_WAIT));
`else
    // Strict A priority: no counter, MAX_WAIT only feeds a lint sink
    logic [7:0] w_unused_max_wait;
    assign w_unused_max_wait = 8'(MAX_WAIT);
    assign w_wait_cnt        = 8'd0;
    assign w_force_b         = 1'b0;
`endif

    // State register; reset abandons any burst in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant decision and next state; a burst only ends on a granted last beat
    always_comb begin
        w_next_state = r_state;
        w_a_gnt      = 1'b0;
        w_b_gnt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.a_req && !w_force_b) begin
                    w_a_gnt = 1'b1;
                end else if (bus.b_req) begin
                    w_b_gnt = 1'b1;
                    if (bus.b_burst && !bus.b_last) begin
                        w_next_state = B_BURST;
                    end
                end
            end
            B_BURST: begin
                w_b_gnt = bus.b_req;
                if (bus.b_req && bus.b_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory port mux: granted requester drives, otherwise everything parks at zero
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = {N{1'b0}};
        bus.mem_wdata = {N{1'b0}};
        if (w_a_gnt) begin
            bus.mem_we    = bus.a_we;
            bus.mem_re    = ~bus.a_we;
            bus.mem_addr  = bus.a_addr;
            bus.mem_wdata = bus.a_wdata;
        end else if (w_b_gnt) begin
            bus.mem_we    = bus.b_we;
            bus.mem_re    = ~bus.b_we;
            bus.mem_addr  = bus.b_addr;
            bus.mem_wdata = bus.b_wdata;
        end
    end

    // Port A read return: capture on granted load, data held until the next load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_rdata  <= {N{1'b0}};
            r_a_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt && !bus.a_we;
            if (w_a_gnt && !bus.a_we) begin
                r_a_rdata <= bus.mem_rdata;
            end
        end
    end

    // Port B read return: same scheme as port A
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b_rdata  <= {N{1'b0}};
            r_b_rvalid <= 1'b0;
        end else begin
            r_b_rvalid <= w_b_gnt && !bus.b_we;
            if (w_b_gnt && !bus.b_we) begin
                r_b_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.a_gnt      = w_a_gnt;
    assign bus.a_stall    = bus.a_req & ~w_a_gnt;
    assign bus.a_rdata    = r_a_rdata;
    assign bus.a_rvalid   = r_a_rvalid;
    assign bus.b_gnt      = w_b_gnt;
    assign bus.b_rdata    = r_b_rdata;
    assign bus.b_rvalid   = r_b_rvalid;
    assign bus.b_wait_cnt = w_wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small dmem model (64 words, addr[8:3]).
// Latency: checks grant/mem drive in the request cycle, rvalid/rdata one cycle later.
// Backpressure: exercises A stall under B bursts, idle beats, mid-burst reset, fairness.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.N(64)) bus ();

    dmem_arbiter #(.N(64), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem model: combinational read, write at clock edge, word 2 (addr 0x10) preloaded
    logic [63:0] mem [0:63];
    assign bus.mem_rdata = mem[bus.mem_addr[8:3]];
    always @(posedge clk) begin
        if (!reset) begin
            mem[2] <= 64'hDEAD;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[8:3]] <= bus.mem_wdata;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle (sample point)
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] exp_cnt;
        logic        exp_b;

        reset          = 1'b0;
        bus.a_req      = 1'b0;
        bus.a_we       = 1'b0;
        bus.a_addr     = '0;
        bus.a_wdata    = '0;
        bus.b_req      = 1'b0;
        bus.b_we       = 1'b0;
        bus.b_addr     = '0;
        bus.b_wdata    = '0;
        bus.b_burst    = 1'b0;
        bus.b_last     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        check("rst_a_rvalid", 64'(bus.a_rvalid), 64'd0);
        check("rst_b_rvalid", 64'(bus.b_rvalid), 64'd0);
        check("rst_a_rdata", bus.a_rdata, 64'd0);
        check("rst_b_rdata", bus.b_rdata, 64'd0);
        check("rst_wait_cnt", 64'(bus.b_wait_cnt), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_re", 64'(bus.mem_re), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        cyc();
        reset = 1'b1;

        // A load of 0x10 (preloaded 0xDEAD)
        bus.a_req  = 1'b1;
        bus.a_we   = 1'b0;
        bus.a_addr = 64'h10;
        smp();
        check("ld_a_gnt", 64'(bus.a_gnt), 64'd1);
        check("ld_mem_re", 64'(bus.mem_re), 64'd1);
        check("ld_mem_we", 64'(bus.mem_we), 64'd0);
        check("ld_mem_addr", bus.mem_addr, 64'h10);
        check("ld_b_gnt", 64'(bus.b_gnt), 64'd0);
        check("ld_a_stall", 64'(bus.a_stall), 64'd0);
        cyc();
        bus.a_req = 1'b0;
        smp();
        check("ld_a_rvalid", 64'(bus.a_rvalid), 64'd1);
        check("ld_a_rdata", bus.a_rdata, 64'hDEAD);
        check("ld_b_rvalid", 64'(bus.b_rvalid), 64'd0);
        check("idle_mem_re", 64'(bus.mem_re), 64'd0);
        check("idle_mem_addr", bus.mem_addr, 64'd0);
        cyc();
        smp();
        check("ld_rvalid_pulse", 64'(bus.a_rvalid), 64'd0);
        check("ld_rdata_hold", bus.a_rdata, 64'hDEAD);

        // A store 0x1234 @0x8 then load @0x8
        cyc();
        bus.a_req   = 1'b1;
        bus.a_we    = 1'b1;
        bus.a_addr  = 64'h8;
        bus.a_wdata = 64'h1234;
        smp();
        check("st_mem_we", 64'(bus.mem_we), 64'd1);
        check("st_mem_wdata", bus.mem_wdata, 64'h1234);
        check("st_mem_addr", bus.mem_addr, 64'h8);
        cyc();
        bus.a_we = 1'b0;
        smp();
        check("st_ld_mem_re", 64'(bus.mem_re), 64'd1);
        check("st_no_rvalid", 64'(bus.a_rvalid), 64'd0);
        cyc();
        bus.a_req = 1'b0;
        smp();
        check("st_ld_rvalid", 64'(bus.a_rvalid), 64'd1);
        check("st_ld_rdata", bus.a_rdata, 64'h1234);

        // Contention: A and B both held, single beats
        cyc();
        bus.a_req   = 1'b1;
        bus.a_we    = 1'b0;
        bus.a_addr  = 64'h10;
        bus.b_req   = 1'b1;
        bus.b_we    = 1'b0;
        bus.b_addr  = 64'h8;
        bus.b_burst = 1'b0;
        bus.b_last  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
`ifdef DMEM_ARB_FAIRNESS_EN
            exp_b   = (k == 9);
            exp_cnt = (k <= 9) ? 64'(k - 1) : 64'(k - 10);
`else
            exp_b   = 1'b0;
            exp_cnt = 64'd0;
`endif
            smp();
            check($sformatf("cont_a_gnt_%0d", k), 64'(bus.a_gnt), 64'(!exp_b));
            check($sformatf("cont_b_gnt_%0d", k), 64'(bus.b_gnt), 64'(exp_b));
            check($sformatf("cont_a_stall_%0d", k), 64'(bus.a_stall), 64'(exp_b));
            check($sformatf("cont_cnt_%0d", k), 64'(bus.b_wait_cnt), exp_cnt);
            cyc();
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        smp();
`ifdef DMEM_ARB_FAIRNESS_EN
        check("cont_b_rdata", bus.b_rdata, 64'h1234);
`else
        check("cont_b_rdata", bus.b_rdata, 64'd0);
`endif

        // B burst of 4 stores, A requesting from beat 2 onward
        cyc();
        bus.b_req   = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_burst = 1'b1;
        bus.b_last  = 1'b0;
        bus.b_addr  = 64'h40;
        bus.b_wdata = 64'hA0;
        smp();
        check("bst_b1_gnt", 64'(bus.b_gnt), 64'd1);
        check("bst_b1_we", 64'(bus.mem_we), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            bus.a_req   = 1'b1;
            bus.a_we    = 1'b0;
            bus.a_addr  = 64'h10;
            bus.b_addr  = 64'h40 + 64'(8 * (i - 1));
            bus.b_wdata = 64'hA0 + 64'(i - 1);
            bus.b_last  = (i == 4);
            smp();
            check($sformatf("bst_b%0d_gnt", i), 64'(bus.b_gnt), 64'd1);
            check($sformatf("bst_b%0d_a_gnt", i), 64'(bus.a_gnt), 64'd0);
            check($sformatf("bst_b%0d_stall", i), 64'(bus.a_stall), 64'd1);
            check($sformatf("bst_b%0d_addr", i), bus.mem_addr, 64'h40 + 64'(8 * (i - 1)));
        end
        cyc();
        bus.b_req   = 1'b0;
        bus.b_burst = 1'b0;
        bus.b_last  = 1'b0;
        smp();
        check("bst_end_a_gnt", 64'(bus.a_gnt), 64'd1);
        check("bst_end_stall", 64'(bus.a_stall), 64'd0);
        check("bst_no_b_rvalid", 64'(bus.b_rvalid), 64'd0);
        cyc();
        bus.a_req = 1'b0;

        // B load burst with a 2-cycle request gap
        bus.b_req   = 1'b1;
        bus.b_we    = 1'b0;
        bus.b_burst = 1'b1;
        bus.b_last  = 1'b0;
        bus.b_addr  = 64'h40;
        smp();
        check("gap_b1_re", 64'(bus.mem_re), 64'd1);
        cyc();
        bus.a_req  = 1'b1;
        bus.b_addr = 64'h48;
        smp();
        check("gap_b2_rvalid", 64'(bus.b_rvalid), 64'd1);
        check("gap_b2_rdata", bus.b_rdata, 64'hA0);
        check("gap_b2_stall", 64'(bus.a_stall), 64'd1);
        cyc();
        bus.b_req  = 1'b0;
        bus.b_last = 1'b1;
        smp();
        check("gap1_mem_we", 64'(bus.mem_we), 64'd0);
        check("gap1_mem_re", 64'(bus.mem_re), 64'd0);
        check("gap1_a_gnt", 64'(bus.a_gnt), 64'd0);
        check("gap1_stall", 64'(bus.a_stall), 64'd1);
        check("gap1_rdata", bus.b_rdata, 64'hA1);
        cyc();
        bus.b_last = 1'b0;
        smp();
        check("gap2_mem_re", 64'(bus.mem_re), 64'd0);
        check("gap2_stall", 64'(bus.a_stall), 64'd1);
        check("gap2_rvalid", 64'(bus.b_rvalid), 64'd0);
        check("gap2_rdata_hold", bus.b_rdata, 64'hA1);
        cyc();
        bus.b_req  = 1'b1;
        bus.b_last = 1'b1;
        bus.b_addr = 64'h50;
        smp();
        check("gap_b3_gnt", 64'(bus.b_gnt), 64'd1);
        check("gap_b3_addr", bus.mem_addr, 64'h50);
        check("gap_b3_stall", 64'(bus.a_stall), 64'd1);
        cyc();
        bus.b_req   = 1'b0;
        bus.b_burst = 1'b0;
        bus.b_last  = 1'b0;
        smp();
        check("gap_end_a_gnt", 64'(bus.a_gnt), 64'd1);
        check("gap_end_rdata", bus.b_rdata, 64'hA2);
        cyc();
        bus.a_req = 1'b0;

        // b_last without b_burst: single beat, stays IDLE
        bus.b_req  = 1'b1;
        bus.b_last = 1'b1;
        bus.b_addr = 64'h58;
        smp();
        check("sgl_b_gnt", 64'(bus.b_gnt), 64'd1);
        cyc();
        bus.b_req  = 1'b0;
        bus.b_last = 1'b0;
        bus.a_req  = 1'b1;
        smp();
        check("sgl_a_gnt", 64'(bus.a_gnt), 64'd1);
        check("sgl_rdata", bus.b_rdata, 64'hA3);
        cyc();
        bus.a_req = 1'b0;

        // Reset pulsed during beat 2 of a B load burst
        bus.b_req   = 1'b1;
        bus.b_burst = 1'b1;
        bus.b_we    = 1'b0;
        bus.b_addr  = 64'h40;
        cyc();
        bus.a_req  = 1'b1;
        bus.a_addr = 64'h10;
        bus.b_addr = 64'h48;
        smp();
        check("rb_b2_stall", 64'(bus.a_stall), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rb_rvalid_clr", 64'(bus.b_rvalid), 64'd0);
        check("rb_rdata_clr", bus.b_rdata, 64'd0);
        bus.b_req   = 1'b0;
        bus.b_burst = 1'b0;
        cyc();
        reset = 1'b1;
        smp();
        check("rb_a_gnt", 64'(bus.a_gnt), 64'd1);
        check("rb_a_stall", 64'(bus.a_stall), 64'd0);
        check("rb_b_rvalid", 64'(bus.b_rvalid), 64'd0);
        check("rb_wait_cnt", 64'(bus.b_wait_cnt), 64'd0);
        cyc();
        bus.a_req = 1'b0;
        smp();
        check("rb_a_rvalid", 64'(bus.a_rvalid), 64'd1);
        check("rb_a_rdata", bus.a_rdata, 64'hDEAD);
        check("rb_b_rvalid2", 64'(bus.b_rvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
